// File: rtl/hex_display_scanner.sv
// hex_display_scanner: multi-digit hex seven-segment driver.
// Holds a shadow copy of the displayed value and drives every digit in parallel
// on HexAll, plus one time-multiplexed Seg/DigitSel pair for scanned displays.
// Each digit can be blanked, blinked, or suppressed as a leading zero.
module hex_display_scanner #(
    parameter int NUM_DIGITS = 4,
    parameter int SCAN_DIV   = 1000,
    parameter int BLINK_DIV  = 250
) (
    input  logic                      Clk,
    input  logic                      Reset,
    input  logic                      Load,
    input  logic [4*NUM_DIGITS-1:0]   Value,
    input  logic [NUM_DIGITS-1:0]     BlankMask,
    input  logic [NUM_DIGITS-1:0]     BlinkMask,
    input  logic                      LzbEn,
    output logic [0:6]                Seg,
    output logic [NUM_DIGITS-1:0]     DigitSel,
    output logic [7*NUM_DIGITS-1:0]   HexAll
);

    // Counter widths are kept at least one bit wide so the degenerate
    // NUM_DIGITS=1 / BLINK_DIV=1 builds still elaborate cleanly.
    localparam int DIV_W = (SCAN_DIV  > 1) ? $clog2(SCAN_DIV)   : 1;
    localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int SCN_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV)  : 1;

    localparam logic [0:6] BLANK = 7'b1111111;

    logic [4*NUM_DIGITS-1:0] shadow_q, shadow_d;
    logic [DIV_W-1:0]        div_q, div_d;
    logic [IDX_W-1:0]        idx_q, idx_d;
    logic [SCN_W-1:0]        scan_q, scan_d;
    logic                    blink_on_q, blink_on_d;
    logic [0:6]              seg_q, seg_d;
    logic [NUM_DIGITS-1:0]   digitsel_q, digitsel_d;
    logic [7*NUM_DIGITS-1:0] hexall_q, hexall_d;

    logic                    div_wrap, idx_wrap, scan_wrap;
    logic                    zero_run;
    logic                    blank;
    logic [0:6]              digit_glyph [NUM_DIGITS];

    // Active-low glyph table, bit 0 = segment a .. bit 6 = segment g.
    function automatic logic [0:6] glyph(input logic [3:0] nib);
        logic [0:6] g;
        case (nib)
            4'h0: g = 7'b0000001;
            4'h1: g = 7'b1001111;
            4'h2: g = 7'b0010010;
            4'h3: g = 7'b0000110;
            4'h4: g = 7'b1001100;
            4'h5: g = 7'b0100100;
            4'h6: g = 7'b0100000;
            4'h7: g = 7'b0001111;
            4'h8: g = 7'b0000000;
            4'h9: g = 7'b0000100;
            4'hA: g = 7'b0001000;
            4'hB: g = 7'b1100000;
            4'hC: g = 7'b0110001;
            4'hD: g = 7'b1000010;
            4'hE: g = 7'b0110000;
            default: g = 7'b0111000;
        endcase
        return g;
    endfunction

    // Next state of the shadow register and the slot/scan/blink timing chain.
    always_comb begin
        shadow_d   = Load ? Value : shadow_q;
        div_wrap   = (div_q  == DIV_W'(SCAN_DIV - 1));
        idx_wrap   = (idx_q  == IDX_W'(NUM_DIGITS - 1));
        scan_wrap  = (scan_q == SCN_W'(BLINK_DIV - 1));
        div_d      = div_wrap ? '0 : div_q + DIV_W'(1);
        idx_d      = idx_q;
        scan_d     = scan_q;
        blink_on_d = blink_on_q;
        if (div_wrap) begin
            if (idx_wrap) begin
                idx_d = '0;
                if (scan_wrap) begin
                    scan_d     = '0;
                    blink_on_d = ~blink_on_q;
                end else begin
                    scan_d = scan_q + SCN_W'(1);
                end
            end else begin
                idx_d = idx_q + IDX_W'(1);
            end
        end
    end

    // Per-digit glyphs with blanking applied; leading-zero suppression walks
    // down from the top digit and stops at the first non-zero nibble.
    always_comb begin
        zero_run   = 1'b1;
        blank      = 1'b0;
        seg_d      = BLANK;
        digitsel_d = '0;
        hexall_d   = '1;
        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            zero_run = zero_run & (shadow_q[4*i +: 4] == 4'h0);
            blank    = BlankMask[i] | (BlinkMask[i] & ~blink_on_q) |
                       (LzbEn & (i > 0) & zero_run);
            digit_glyph[i] = blank ? BLANK : glyph(shadow_q[4*i +: 4]);
        end
        for (int i = 0; i < NUM_DIGITS; i++) begin
            for (int k = 0; k < 7; k++) begin
                hexall_d[7*i + k] = digit_glyph[i][k];
            end
            digitsel_d[i] = (idx_q == IDX_W'(i));
            if (idx_q == IDX_W'(i)) begin
                seg_d = digit_glyph[i];
            end
        end
    end

    // State and registered outputs; reset wins over Load and blanks the display.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            shadow_q   <= '0;
            div_q      <= '0;
            idx_q      <= '0;
            scan_q     <= '0;
            blink_on_q <= 1'b1;
            seg_q      <= BLANK;
            digitsel_q <= '0;
            hexall_q   <= '1;
        end else begin
            shadow_q   <= shadow_d;
            div_q      <= div_d;
            idx_q      <= idx_d;
            scan_q     <= scan_d;
            blink_on_q <= blink_on_d;
            seg_q      <= seg_d;
            digitsel_q <= digitsel_d;
            hexall_q   <= hexall_d;
        end
    end

    assign Seg      = seg_q;
    assign DigitSel = digitsel_q;
    assign HexAll   = hexall_q;

endmodule

// File: tb/tb_hex_display_scanner.sv
// Scoreboard bench for hex_display_scanner (4 digits, 4 clocks per slot,
// 2 scans per blink half-period).
module tb_hex_display_scanner;

    logic        Clk = 1'b0;
    logic        Reset, Load, LzbEn;
    logic [15:0] Value;
    logic [3:0]  BlankMask, BlinkMask;
    logic [0:6]  Seg;
    logic [3:0]  DigitSel;
    logic [27:0] HexAll;

    hex_display_scanner #(.NUM_DIGITS(4), .SCAN_DIV(4), .BLINK_DIV(2)) dut (
        .Clk(Clk), .Reset(Reset), .Load(Load), .Value(Value),
        .BlankMask(BlankMask), .BlinkMask(BlinkMask), .LzbEn(LzbEn),
        .Seg(Seg), .DigitSel(DigitSel), .HexAll(HexAll)
    );

    always #5 Clk = ~Clk;

    localparam logic [0:6] G0  = 7'b0000001;
    localparam logic [0:6] G1  = 7'b1001111;
    localparam logic [0:6] G2  = 7'b0010010;
    localparam logic [0:6] GA  = 7'b0001000;
    localparam logic [0:6] GB  = 7'b1100000;
    localparam logic [0:6] GF  = 7'b0111000;
    localparam logic [0:6] BLK = 7'b1111111;

    int          edge_cnt = 0;
    int          rel = 0;
    int          n_cmp = 0;
    int          n_bad = 0;
    logic [0:6]  g_norm [4];
    logic [3:0]  blink_m = 4'b0000;

    int          q_edge [$];
    string       q_name [$];
    logic [0:6]  q_seg  [$];
    logic [3:0]  q_ds   [$];
    bit          q_chk  [$];
    logic [27:0] q_hex  [$];

    always @(posedge Clk) edge_cnt++;

    function automatic logic [27:0] pack4(input logic [0:6] d3, input logic [0:6] d2,
                                          input logic [0:6] d1, input logic [0:6] d0);
        logic [27:0] r;
        for (int k = 0; k < 7; k++) begin
            r[k]      = d0[k];
            r[7 + k]  = d1[k];
            r[14 + k] = d2[k];
            r[21 + k] = d3[k];
        end
        return r;
    endfunction

    task automatic push(input string name, input int at_edge, input logic [0:6] s,
                        input logic [3:0] ds, input bit chk, input logic [27:0] hx);
        q_edge.push_back(at_edge);
        q_name.push_back(name);
        q_seg.push_back(s);
        q_ds.push_back(ds);
        q_chk.push_back(chk);
        q_hex.push_back(hx);
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    // Expected scan position follows directly from slot time since reset release.
    task automatic run(input int n, input bit chk_hex, input string name);
        for (int j = 0; j < n; j++) begin
            int         t;
            int         ix;
            logic [3:0] oh;
            logic [0:6] d [4];
            t  = edge_cnt + 1 - rel;
            ix = ((t - 1) / 4) % 4;
            oh = 4'b0001 << ix;
            for (int i = 0; i < 4; i++)
                d[i] = (blink_m[i] && (((t - 1) / 32) % 2 == 1)) ? BLK : g_norm[i];
            push(name, edge_cnt + 1, d[ix], oh, chk_hex, pack4(d[3], d[2], d[1], d[0]));
            tick();
        end
    endtask

    task automatic push_reset(input string name);
        push(name, edge_cnt + 1, BLK, 4'b0000, 1'b1, 28'hFFFFFFF);
    endtask

    // Monitor: pops every expectation due at the current edge and compares.
    always @(negedge Clk) begin
        while (q_edge.size() != 0 && q_edge[0] <= edge_cnt) begin
            if (q_edge[0] != edge_cnt) begin
                n_cmp++; n_bad++;
                $display("FAIL %s stale entry: edge %0d seen at %0d", q_name[0], q_edge[0], edge_cnt);
            end else begin
                n_cmp++;
                if (Seg !== q_seg[0]) begin
                    n_bad++;
                    $display("FAIL %s seg @%0d: got %b want %b", q_name[0], edge_cnt, Seg, q_seg[0]);
                end
                n_cmp++;
                if (DigitSel !== q_ds[0]) begin
                    n_bad++;
                    $display("FAIL %s digitsel @%0d: got %b want %b", q_name[0], edge_cnt, DigitSel, q_ds[0]);
                end
                if (q_chk[0]) begin
                    n_cmp++;
                    if (HexAll !== q_hex[0]) begin
                        n_bad++;
                        $display("FAIL %s hexall @%0d: got %h want %h", q_name[0], edge_cnt, HexAll, q_hex[0]);
                    end
                end
            end
            void'(q_edge.pop_front());
            void'(q_name.pop_front());
            void'(q_seg.pop_front());
            void'(q_ds.pop_front());
            void'(q_chk.pop_front());
            void'(q_hex.pop_front());
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached, %0d entries pending", q_edge.size());
        $fatal(1, "timeout");
    end

    initial begin
        Reset = 1'b1; Load = 1'b0; Value = 16'h0000;
        BlankMask = 4'b0000; BlinkMask = 4'b0000; LzbEn = 1'b0;
        for (int i = 0; i < 4; i++) g_norm[i] = G0;

        // Reset held for three clocks.
        for (int i = 0; i < 3; i++) begin
            push_reset("reset");
            tick();
        end

        // Release reset and load 1A2F on the first free edge.
        rel = edge_cnt;
        Reset = 1'b0; Load = 1'b1; Value = 16'h1A2F;
        run(1, 1'b1, "first_slot");
        Load = 1'b0;
        g_norm[0] = GF; g_norm[1] = G2; g_norm[2] = GA; g_norm[3] = G1;
        run(20, 1'b1, "scan_1A2F");

        // Leading-zero suppression on an all-zero value.
        LzbEn = 1'b1; Load = 1'b1; Value = 16'h0000;
        tick();
        Load = 1'b0;
        g_norm[0] = G0; g_norm[1] = BLK; g_norm[2] = BLK; g_norm[3] = BLK;
        run(6, 1'b1, "lzb_0000");

        // Leading-zero suppression stops at the first non-zero nibble.
        Load = 1'b1; Value = 16'h00B0;
        tick();
        Load = 1'b0;
        g_norm[0] = G0; g_norm[1] = GB; g_norm[2] = BLK; g_norm[3] = BLK;
        run(6, 1'b1, "lzb_00B0");

        // Blink digit 2 across several blink half-periods.
        LzbEn = 1'b0; BlinkMask = 4'b0100; Load = 1'b1; Value = 16'h1A2F;
        tick();
        Load = 1'b0;
        g_norm[0] = GF; g_norm[1] = G2; g_norm[2] = GA; g_norm[3] = G1;
        blink_m = 4'b0100;
        run(70, 1'b1, "blink_d2");

        // Permanent blank on digit 0.
        BlinkMask = 4'b0000; BlankMask = 4'b0001;
        tick();
        blink_m = 4'b0000;
        g_norm[0] = BLK;
        run(20, 1'b1, "blank_d0");

        // Reset mid-scan with Load held high: reset must win.
        Reset = 1'b1; Load = 1'b1; Value = 16'hFFFF; BlankMask = 4'b0000;
        for (int i = 0; i < 2; i++) begin
            push_reset("reset_mid");
            tick();
        end
        rel = edge_cnt;
        Reset = 1'b0; Load = 1'b0;
        for (int i = 0; i < 4; i++) g_norm[i] = G0;
        run(8, 1'b1, "after_reset");

        for (int i = 0; i < 3 && q_edge.size() != 0; i++) tick();
        if (q_edge.size() != 0) begin
            n_cmp++; n_bad++;
            $display("FAIL drain: %0d entries never compared, want 0", q_edge.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
